// File: rtl/sram_ctrl.sv
// sram_ctrl: turns one 32-bit MEM-stage load/store into two 16-bit accesses
// (low half, then high half) on an asynchronous SRAM, freezing the pipeline
// via ready=0 until the word transfer is complete.
//
// Optional build macro SRAM_CTRL_ADDR_CHECK_EN: out-of-range requests skip the
// SRAM, go straight to DONE and raise addr_error for that one cycle. Without
// it, addresses wrap modulo the SRAM size and addr_error is tied low.
//
// All SRAM strobes are registered from the next-state decode so the pins are
// glitch-free and change only on clock edges.
module sram_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_en,
  input  logic               write_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic               addr_error,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [15:0]        sram_dq_in,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLo   = 2'd1;
  localparam logic [1:0] StHi   = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [31:0] BaseAddr = BASE_ADDR;
  localparam logic [2:0]  CntLast  = 3'(WAIT_CYCLES - 1);
  localparam int unsigned WordW    = SRAM_AW - 1;

  logic [1:0]         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               op_wr_q, op_wr_d;
  logic [WordW-1:0]   word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        read_data_q, read_data_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               dq_oe_q, dq_oe_d;
  logic               we_n_q, we_n_d;
  logic               oe_n_q, oe_n_d;
  logic               ce_n_q, ce_n_d;
  logic               bl_n_q, bl_n_d;

  logic [31:0] off;
  logic        req;
  logic        last_wait;

  assign off       = address - BaseAddr;
  assign req       = read_en | write_en;
  assign last_wait = (cnt_q == CntLast);

  // Byte-lane bits and (in the wrapping build) the bits above the SRAM size
  // are intentionally dropped.
  logic unused_off;
  assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  logic range_err;
  logic addr_error_q, addr_error_d;
  assign range_err  = (address < BaseAddr) || (off[31:SRAM_AW+1] != '0);
  assign addr_error = addr_error_q;
`else
  assign addr_error = 1'b0;
`endif

  // Next-state: sequence IDLE -> LO -> HI -> DONE, latching the request on entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    addr_error_d = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = 3'd0;
        if (req) begin
          op_wr_d = write_en;  // write wins when both are asserted
          word_d  = off[SRAM_AW:2];
          wdata_d = write_data;
          state_d = StLo;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
          if (range_err) begin
            state_d      = StDone;
            addr_error_d = 1'b1;
          end
`endif
        end
      end
      StLo: begin
        if (last_wait) begin
          state_d = StHi;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StHi: begin
        if (last_wait) begin
          state_d = StDone;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Bus drive for the upcoming cycle, decoded from the next state.
  always_comb begin
    sram_addr_d = sram_addr_q;
    dq_out_d    = 16'h0000;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    ce_n_d      = 1'b1;
    bl_n_d      = 1'b1;
    if ((state_d == StLo) || (state_d == StHi)) begin
      ce_n_d      = 1'b0;
      bl_n_d      = 1'b0;
      sram_addr_d = {word_d, (state_d == StHi)};
      if (op_wr_d) begin
        dq_oe_d  = 1'b1;
        dq_out_d = (state_d == StHi) ? wdata_d[31:16] : wdata_d[15:0];
        // Release we_n in the final wait cycle so data is held past the strobe.
        we_n_d   = (cnt_d == CntLast);
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  // Read capture: sample the SRAM at the end of each half's final wait cycle.
  always_comb begin
    read_data_d = read_data_q;
    if (!op_wr_q && last_wait) begin
      if (state_q == StLo) begin
        read_data_d[15:0] = sram_dq_in;
      end else if (state_q == StHi) begin
        read_data_d[31:16] = sram_dq_in;
      end
    end
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    if ((state_q == StIdle) && req && range_err && !write_en) begin
      read_data_d = 32'h0;
    end
`endif
  end

  // Pipeline freeze: combinational in IDLE so the request cycle itself stalls.
  always_comb begin
    ready = 1'b0;
    if (state_q == StIdle) begin
      ready = ~req;
    end else if (state_q == StDone) begin
      ready = 1'b1;
    end
  end

  // State and registered SRAM pins, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      op_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= 32'h0;
      read_data_q <= 32'h0;
      sram_addr_q <= '0;
      dq_out_q    <= 16'h0000;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
      bl_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      ce_n_q      <= ce_n_d;
      bl_n_q      <= bl_n_d;
    end
  end

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  // Range-error flag, high only during the DONE cycle it caused.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_error_q <= 1'b0;
    end else begin
      addr_error_q <= addr_error_d;
    end
  end
`endif

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_ub_n   = bl_n_q;
  assign sram_lb_n   = bl_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a small behavioural async SRAM model.
module tb_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        read_en;
  logic        write_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        addr_error;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_in;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ce_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  int total;
  int bad;

  logic [15:0] mem [0:255];

  sram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .read_en    (read_en),
    .write_en   (write_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .addr_error (addr_error),
    .sram_addr  (sram_addr),
    .sram_dq_in (sram_dq_in),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .sram_ce_n  (sram_ce_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: combinational read, write on edge while we_n is low.
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      mem[sram_addr[7:0]] = sram_dq_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full access starting in an IDLE cycle; ends at posedge+1 after DONE.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [17:0] lo,
                            input logic [31:0] exp_rd, input string tag);
    read_en    = rd;
    write_en   = wr;
    address    = addr;
    write_data = wdata;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk({tag, "/ready"}, 32'(ready), 32'(c == 5));
      if (c == 0 || c == 5) begin
        chk({tag, "/ce_n_idle"}, 32'(sram_ce_n), 32'd1);
        chk({tag, "/we_n_idle"}, 32'(sram_we_n), 32'd1);
      end else begin
        chk({tag, "/ce_n"}, 32'(sram_ce_n), 32'd0);
        chk({tag, "/lb_n"}, 32'(sram_lb_n), 32'd0);
        chk({tag, "/addr"}, 32'(sram_addr), (c < 3) ? 32'(lo) : 32'(lo) + 32'd1);
        if (wr) begin
          chk({tag, "/we_n"}, 32'(sram_we_n), 32'(c == 2 || c == 4));
          chk({tag, "/dq_oe"}, 32'(sram_dq_oe), 32'd1);
          chk({tag, "/dq_out"}, 32'(sram_dq_out),
              (c < 3) ? 32'(wdata[15:0]) : 32'(wdata[31:16]));
        end else begin
          chk({tag, "/oe_n"}, 32'(sram_oe_n), 32'd0);
          chk({tag, "/we_n_rd"}, 32'(sram_we_n), 32'd1);
        end
      end
      if (c == 5) chk({tag, "/read_data"}, read_data, exp_rd);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    read_en    = 1'b0;
    write_en   = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst/ready", 32'(ready), 32'd1);
    chk("rst/read_data", read_data, 32'h0);
    chk("rst/sram_addr", 32'(sram_addr), 32'h0);
    chk("rst/strobes", {27'h0, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n},
        32'h1f);
    chk("rst/dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst/dq_out", 32'(sram_dq_out), 32'h0);
    chk("rst/addr_error", 32'(addr_error), 32'd0);
    @(posedge clk);
    #1;

    // Write 0xDEADBEEF to 1024 -> halfwords 0/1
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0, 32'h0, "wr1024");
    write_en = 1'b0;
    chk("wr1024/mem0", 32'(mem[0]), 32'h0000BEEF);
    chk("wr1024/mem1", 32'(mem[1]), 32'h0000DEAD);
    @(negedge clk);
    chk("wr1024/idle_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1;

    // Read it back
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 32'hDEADBEEF, "rd1024");
    read_en = 1'b0;

    // Address mapping: 1036 -> halfwords 6/7, byte-offset bits ignored
    mem[6] = 16'h1234;
    mem[7] = 16'h5678;
    run_access(1'b1, 1'b0, 32'd1039, 32'h0, 18'd6, 32'h56781234, "rd1039");
    read_en = 1'b0;

    // Both strobes: write wins, read_data keeps its value
    run_access(1'b1, 1'b1, 32'd1028, 32'h00000001, 18'd2, 32'h56781234, "both1028");
    read_en  = 1'b0;
    write_en = 1'b0;
    chk("both1028/mem2", 32'(mem[2]), 32'h00000001);
    chk("both1028/mem3", 32'(mem[3]), 32'h00000000);

    // Back-to-back reads held high
    run_access(1'b1, 1'b0, 32'd1036, 32'h0, 18'd6, 32'h56781234, "b2b_a");
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 32'hDEADBEEF, "b2b_b");
    read_en = 1'b0;

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    // Out-of-range read below BASE_ADDR
    read_en = 1'b1;
    address = 32'd512;
    @(negedge clk);
    chk("oor/c0_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("oor/c1_ready", 32'(ready), 32'd1);
    chk("oor/c1_addr_error", 32'(addr_error), 32'd1);
    chk("oor/c1_read_data", read_data, 32'h0);
    chk("oor/c1_ce_n", 32'(sram_ce_n), 32'd1);
    @(posedge clk);
    #1;
    read_en = 1'b0;
    @(negedge clk);
    chk("oor/c2_addr_error", 32'(addr_error), 32'd0);
    chk("oor/c2_ce_n", 32'(sram_ce_n), 32'd1);
    @(posedge clk);
    #1;
`endif

    // Reset while in HI of a write
    write_en   = 1'b1;
    address    = 32'd1024;
    write_data = 32'h11112222;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("rstmid/hi_ce_n", 32'(sram_ce_n), 32'd0);
    chk("rstmid/hi_addr", 32'(sram_addr), 32'd1);
    chk("rstmid/hi_we_n", 32'(sram_we_n), 32'd0);
    rst      = 1'b0;
    write_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid/ready", 32'(ready), 32'd1);
    chk("rstmid/we_n", 32'(sram_we_n), 32'd1);
    chk("rstmid/dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rstmid/ce_n", 32'(sram_ce_n), 32'd1);
    chk("rstmid/read_data", read_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
